time_set_ctrl: RTL and testbench
================================

// Module: time_set_ctrl
// PURPOSE
//  Button-driven set controller and write initiator for the real-time BCD counter.
//  Drives the counter's set_time[7:0] / enable[2:0] / save inputs.
//  User selects hour, then min, then sec; adjusts the selected field in BCD; commits one field per save.
//  Sits between the debounced button front end and the counter; same clk as the counter.
// PARAMETERS
//  TIMEOUT_CYCLES  30  idle cycles in an edit state before edit is abandoned (only with TIMEOUT_EN)
// PORTS
//  clk        in   1  system clock (counter tick clock)
//  reset_n    in   1  asynchronous, active-low reset
//  mode_btn   in   1  1-cycle pulse: enter edit / advance field
//  up_btn     in   1  1-cycle pulse: increment edited field
//  down_btn   in   1  1-cycle pulse: decrement edited field
//  ok_btn     in   1  1-cycle pulse: commit edited field
//  cur_hour   in   8  live BCD hour from counter
//  cur_min    in   8  live BCD min from counter
//  cur_sec    in   8  live BCD sec from counter
//  set_time   out  8  BCD value to write; valid while editing
//  enable     out  3  field select: 3'b011 hour, 3'b101 min, 3'b110 sec, 3'b111 none
//  save       out  1  1-cycle write strobe to counter
//  editing    out  1  high in any edit state (for display blink)
// BEHAVIOUR
//  - All outputs are registered. Reset values: set_time=8'h00, enable=3'b111, save=0, editing=0, state=IDLE.
//  - States: IDLE, E_HOUR, E_MIN, E_SEC, COMMIT.
//  - IDLE: on mode_btn, load edit reg <= cur_hour and go to E_HOUR. All other buttons are ignored.
//  - Field advance on mode_btn: E_HOUR->E_MIN loads cur_min; E_MIN->E_SEC loads cur_sec;
//    E_SEC->IDLE discards the edit, with no save.
//  - Field loads take their value at the mode_btn edge, i.e. the counter's value at that cycle.
//  - up_btn: BCD +1. Hour wraps 8'h23->8'h00; min/sec wrap 8'h59->8'h00.
//  - down_btn: BCD -1. Hour wraps 8'h00->8'h23; min/sec wrap 8'h00->8'h59.
//  - Digit rules: ones 9->0 carries to tens; ones 0->9 borrows from tens. Result is always valid BCD.
//  - ok_btn in an edit state: go to COMMIT.
//    In COMMIT, save=1 for exactly one cycle, with enable = current field code and set_time = edit value.
//    Next state is IDLE. The counter loads at the edge ending the COMMIT cycle.
//  - Latency: ok_btn at edge N -> save high during cycle N+1 -> enable=3'b111 and save=0 from edge N+2.
//  - Priority for simultaneous pulses: ok > mode > up/down.
//  - up and down in the same cycle: no change.
//  - enable equals the field code in E_*/COMMIT states and 3'b111 in IDLE.
//  - editing=1 in E_* and COMMIT states, 0 in IDLE.
//  - set_time holds its last value in IDLE; the counter ignores it because save=0.
//  - Buttons during COMMIT are ignored; the next edit requires a fresh mode_btn from IDLE.
//  - reset_n low mid-edit or during COMMIT: outputs go to reset values immediately (async) and no save is issued.
// CONFIGURATION
//  TIME_SET_TIMEOUT_EN defined:
//   - 16-bit idle counter cleared by any button pulse and by each entry into an E_* state.
//   - Reaching TIMEOUT_CYCLES in an E_* state forces IDLE with no save; this is an abandoned edit.
//  Undefined: no counter; edit states persist indefinitely.
// TESTING
//  1. Reset, then mode with cur_hour=8'h22: enable=011, set_time=22.
//     up x2 -> 8'h00; ok -> one-cycle save with enable=011, set_time=8'h00.
//  2. Min edit at 8'h00, down x1 -> 8'h59.
//     Sec edit at 8'h59, up -> 8'h00; 8'h09 up -> 8'h10; 8'h10 down -> 8'h09.
//  3. mode x4 from IDLE: walks hour->min->sec->IDLE with enable 011/101/110/111; save never asserted.
//  4. ok+mode+up in same cycle in E_MIN: goes to COMMIT with unchanged value.
//     up+down together: value unchanged.
//  5. reset_n low during COMMIT: save drops asynchronously to 0, enable=111, editing=0.
//  6. With TIME_SET_TIMEOUT_EN, TIMEOUT_CYCLES=4:
//     no buttons for 4 cycles in E_SEC -> IDLE, no save; an up pulse at cycle 3 restarts the count.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Button-driven hour/min/sec set controller that writes one BCD field per save strobe.
// Optional edit timeout is compiled in with `define TIME_SET_TIMEOUT_EN.
`timescale 1ns/1ps
module time_set_ctrl
`ifdef TIME_SET_TIMEOUT_EN
    #(parameter int unsigned TIMEOUT_CYCLES = 30)
`endif
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mode_btn,
    input  logic       up_btn,
    input  logic       down_btn,
    input  logic       ok_btn,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic [7:0] set_time,
    output logic [2:0] enable,
    output logic       save,
    output logic       editing,
    output logic [2:0] state_dbg
);

    // Write handshake: save is a one-cycle strobe with no back-pressure; enable and
    // set_time are stable for the whole strobe cycle and the counter loads on its closing edge.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOUR   = 3'd1,
        S_MIN    = 3'd2,
        S_SEC    = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] set_time_q, set_time_d;
    logic [2:0] enable_q, enable_d;
    logic       save_q, save_d;
    logic       editing_q, editing_d;
    logic       timeout_hit;
    logic [7:0] field_top;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
        if (v == 8'h00) return top;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [2:0] field_code(input state_t s);
        case (s)
            S_HOUR:  return 3'b011;
            S_MIN:   return 3'b101;
            S_SEC:   return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

`ifdef TIME_SET_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        any_btn;
    logic        in_edit_q;
    logic        edit_entry;

    assign any_btn     = mode_btn | up_btn | down_btn | ok_btn;
    assign in_edit_q   = (state_q == S_HOUR) || (state_q == S_MIN) || (state_q == S_SEC);
    assign timeout_hit = in_edit_q && !any_btn && (idle_cnt_q == TIMEOUT_LAST);
    assign edit_entry  = (state_d != state_q) &&
                         ((state_d == S_HOUR) || (state_d == S_MIN) || (state_d == S_SEC));

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (any_btn || edit_entry || timeout_hit) begin
            idle_cnt_d = 16'd0;
        end else if (in_edit_q) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) idle_cnt_q <= 16'd0;
        else          idle_cnt_q <= idle_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign field_top = (state_q == S_HOUR) ? 8'h23 : 8'h59;

    always_comb begin
        state_d    = state_q;
        set_time_d = set_time_q;
        case (state_q)
            S_IDLE: begin
                if (mode_btn) begin
                    state_d    = S_HOUR;
                    set_time_d = cur_hour;
                end
            end
            S_HOUR, S_MIN, S_SEC: begin
                if (ok_btn) begin
                    state_d = S_COMMIT;
                end else if (mode_btn) begin
                    case (state_q)
                        S_HOUR: begin
                            state_d    = S_MIN;
                            set_time_d = cur_min;
                        end
                        S_MIN: begin
                            state_d    = S_SEC;
                            set_time_d = cur_sec;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end else if (up_btn && !down_btn) begin
                    set_time_d = bcd_inc(set_time_q, field_top);
                end else if (down_btn && !up_btn) begin
                    set_time_d = bcd_dec(set_time_q, field_top);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // COMMIT keeps the code of the field being written.
        enable_d  = (state_d == S_COMMIT) ? field_code(state_q) : field_code(state_d);
        save_d    = (state_d == S_COMMIT);
        editing_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            set_time_q <= 8'h00;
            enable_q   <= 3'b111;
            save_q     <= 1'b0;
            editing_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_time_q <= set_time_d;
            enable_q   <= enable_d;
            save_q     <= save_d;
            editing_q  <= editing_d;
        end
    end

    assign set_time  = set_time_q;
    assign enable    = enable_q;
    assign save      = save_q;
    assign editing   = editing_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a decimal-arithmetic field model predicts every cycle.
`timescale 1ns/1ps
module tb_time_set_ctrl;

    localparam int TMO = 4;
    localparam logic [2:0] CODE [4] = '{3'b111, 3'b011, 3'b101, 3'b110};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       mode_btn = 1'b0, up_btn = 1'b0, down_btn = 1'b0, ok_btn = 1'b0;
    logic [7:0] cur_hour = 8'h00, cur_min = 8'h00, cur_sec = 8'h00;
    logic [7:0] set_time;
    logic [2:0] enable;
    logic       save, editing;
    logic [2:0] state_dbg;

    logic [7:0] want_h = 8'h00, want_m = 8'h00, want_s = 8'h00;

    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int popped = 0;

    logic [12:0] exp_q[$];
    logic [10:0] save_exp_q[$];

    int m_fld = 0;
    int m_val = 0;
    int m_idle = 0;
    bit m_commit = 1'b0;

    always #5 clk = ~clk;

`ifdef TIME_SET_TIMEOUT_EN
    time_set_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
`else
    time_set_ctrl dut (
`endif
        .clk(clk), .reset_n(reset_n),
        .mode_btn(mode_btn), .up_btn(up_btn), .down_btn(down_btn), .ok_btn(ok_btn),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .set_time(set_time), .enable(enable), .save(save), .editing(editing),
        .state_dbg(state_dbg)
    );

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int modv();
        return (m_fld == 1) ? 24 : 60;
    endfunction

    function automatic logic [7:0] rand_bcd(input int top);
        return int2bcd(int'($urandom_range(0, top)));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fld = 0;
        m_val = 0;
        m_idle = 0;
        m_commit = 1'b0;
    endtask

    task automatic model_step(input bit m, input bit u, input bit d, input bit o);
        if (m_commit) begin
            m_commit = 1'b0;
            m_fld = 0;
        end else if (m_fld == 0) begin
            if (m) begin
                m_fld = 1;
                m_val = bcd2int(want_h);
                m_idle = 0;
            end
        end else if (o) begin
            m_commit = 1'b1;
        end else if (m) begin
            if (m_fld == 3) begin
                m_fld = 0;
            end else begin
                m_fld = m_fld + 1;
                m_val = bcd2int((m_fld == 2) ? want_m : want_s);
                m_idle = 0;
            end
        end else if (u && !d) begin
            m_val = (m_val + 1) % modv();
        end else if (d && !u) begin
            m_val = (m_val + modv() - 1) % modv();
`ifdef TIME_SET_TIMEOUT_EN
        end else if (!u && !d) begin
            m_idle = m_idle + 1;
            if (m_idle == TMO) begin
                m_fld = 0;
                m_idle = 0;
            end
`endif
        end
        if (m || u || d || o) m_idle = 0;
    endtask

    // One clock of stimulus; the expectation refers to the outputs after the next edge.
    task automatic cyc(input bit m, input bit u, input bit d, input bit o);
        @(posedge clk);
        #2;
        mode_btn = m; up_btn = u; down_btn = d; ok_btn = o;
        cur_hour = want_h; cur_min = want_m; cur_sec = want_s;
        model_step(m, u, d, o);
        exp_q.push_back({m_commit, (m_fld != 0), CODE[m_fld], int2bcd(m_val)});
        pushed++;
        if (m_commit) save_exp_q.push_back({CODE[m_fld], int2bcd(m_val)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        logic [12:0] e;
        logic [10:0] se;
        #1;
        if (reset_n) begin
            if (save) begin
                if (save_exp_q.size() == 0) begin
                    chk("unexpected_save", 32'(save), 32'd0);
                end else begin
                    se = save_exp_q.pop_front();
                    chk("save_payload", 32'({enable, set_time}), 32'(se));
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                popped++;
                chk("cycle_status", 32'({save, editing, enable, set_time}), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #12;
        chk("reset_set_time", 32'(set_time), 32'h00);
        chk("reset_enable", 32'(enable), 32'b111);
        chk("reset_save", 32'(save), 32'd0);
        chk("reset_editing", 32'(editing), 32'd0);
        chk("reset_state", 32'(state_dbg), 32'd0);
        #10;
        reset_n = 1'b1;

        // hour 22 up twice wraps to 00, then commit
        want_h = 8'h22;
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
        idle(2);

        // min 00 down wraps to 59; sec 59 up wraps to 00; sec 09 up/down across tens
        want_m = 8'h00; want_s = 8'h59;
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(1, 0, 0, 0);
        want_s = 8'h09;
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 1);
        idle(2);

        // mode x4 walks every field and back with no save; hour 00 down wraps to 23
        want_h = 8'h00; want_m = 8'h37; want_s = 8'h48;
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0); cyc(0, 0, 1, 0); cyc(1, 0, 0, 0);

        // ok+mode+up in E_MIN commits the unchanged value; up+down holds
        cyc(0, 1, 1, 0); cyc(1, 1, 0, 1); cyc(1, 1, 1, 1);
        idle(1);
        cyc(1, 0, 0, 0); cyc(0, 1, 1, 0); cyc(0, 0, 0, 1);

        // async reset during COMMIT drops the strobe at once
        @(posedge clk);
        #3;
        chk("commit_save_high", 32'(save), 32'd1);
        mode_btn = 0; up_btn = 0; down_btn = 0; ok_btn = 0;
        reset_n = 1'b0;
        #1;
        chk("rst_commit_save", 32'(save), 32'd0);
        chk("rst_commit_enable", 32'(enable), 32'b111);
        chk("rst_commit_editing", 32'(editing), 32'd0);
        chk("rst_commit_set_time", 32'(set_time), 32'h00);
        model_reset();
        #3;
        reset_n = 1'b1;

`ifdef TIME_SET_TIMEOUT_EN
        // timeout in E_SEC, and an up pulse restarting the idle count
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        idle(5);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        idle(2); cyc(0, 1, 0, 0); idle(5);
`endif

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                want_h = rand_bcd(23);
                want_m = rand_bcd(59);
                want_s = rand_bcd(59);
            end
            if ($urandom_range(0, 15) == 0) begin
                idle(int'($urandom_range(1, 8)));
            end else begin
                cyc($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            end
        end
        idle(3);
        @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("pop_count", 32'(popped), 32'(pushed));
        chk("save_queue_drained", 32'(save_exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
